audio_tone_sequencer: RTL and testbench

//  Controller that schedules notes for the programmable square-wave oscillator in the audio peripheral.
//  The bus writer pushes (half-period, duration) notes into an internal FIFO.
//  The block plays them back-to-back: it loads the oscillator period, gates the oscillator for the duration, then inserts a silent gap.
//  It raises a done pulse when the queue drains.

---
 rtl/audio_tone_sequencer.sv | 174 +++++++++++++++++
 tb/tb_audio_tone_sequencer.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/audio_tone_sequencer.sv
// Note sequencer for the square-wave oscillator: queues (half-period, duration) notes
// and plays them back-to-back with a silent gap, pulsing done when the queue drains.
module audio_tone_sequencer #(
  parameter int FIFO_DEPTH = 8,
  parameter int PERIOD_W   = 18,
  parameter int DUR_W      = 16,
  parameter int TICK_DIV   = 50000,
  parameter int GAP_CYCLES = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          note_valid,
  output logic                          note_ready,
  input  logic [PERIOD_W-1:0]           note_period,
  input  logic [DUR_W-1:0]              note_dur,
  input  logic                          start,
  input  logic                          stop,
  output logic [PERIOD_W-1:0]           osc_period,
  output logic                          osc_load,
  output logic                          osc_enable,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam int PRE_W = $clog2(TICK_DIV);
  localparam int GAP_W = $clog2(GAP_CYCLES) + 1;
  localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(TICK_DIV - 1);
  localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(GAP_CYCLES - 1);
  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, PLAY, GAP} state_t;

  logic [PERIOD_W-1:0] per_mem [FIFO_DEPTH];
  logic [DUR_W-1:0]    dur_mem [FIFO_DEPTH];

  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]    level_q, level_d;
  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] osc_period_q, osc_period_d;
  logic                osc_load_q, osc_load_d;
  logic                osc_enable_q, osc_enable_d;
  logic                done_q, done_d;
  logic [DUR_W-1:0]    remain_q, remain_d;
  logic [PRE_W-1:0]    presc_q, presc_d;
  logic [GAP_W-1:0]    gap_q, gap_d;

  logic                push, pop;
  logic [PERIOD_W-1:0] head_period;
  logic [DUR_W-1:0]    head_dur;

  assign note_ready  = (level_q < LVL_FULL);
  assign pop         = (state_q == LOAD) && !stop;
  // A pop in the same cycle frees the slot, so a write against a full queue still lands.
  assign push        = note_valid && !stop && (note_ready || pop);
  assign level_d     = level_q + LVL_W'(push) - LVL_W'(pop);
  assign head_period = per_mem[rd_ptr_q];
  assign head_dur    = dur_mem[rd_ptr_q];

  always_ff @(posedge CLK) begin
    if (push) begin
      per_mem[wr_ptr_q] <= note_period;
      dur_mem[wr_ptr_q] <= note_dur;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (stop) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      level_q <= level_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    osc_period_d = osc_period_q;
    osc_load_d   = 1'b0;
    osc_enable_d = osc_enable_q;
    done_d       = 1'b0;
    remain_d     = remain_q;
    presc_d      = presc_q;
    gap_d        = gap_q;
    if (stop) begin
      state_d      = IDLE;
      osc_enable_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start && level_q != '0) state_d = LOAD;
        LOAD: begin
          if (head_dur != '0) begin
            osc_period_d = head_period;
            osc_load_d   = 1'b1;
            osc_enable_d = (head_period != '0);
            remain_d     = head_dur;
            presc_d      = '0;
            state_d      = PLAY;
          end else if (level_d != '0) begin
            state_d = LOAD;
          end else begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
        PLAY: begin
          if (presc_q == PRE_MAX) begin
            presc_d  = '0;
            remain_d = remain_q - 1'b1;
            if (remain_q == DUR_W'(1)) begin
              state_d      = GAP;
              osc_enable_d = 1'b0;
              gap_d        = '0;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        GAP: begin
          if (gap_q == GAP_MAX) begin
            if (level_q != '0) begin
              state_d = LOAD;
            end else begin
              state_d = IDLE;
              done_d  = 1'b1;
            end
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= IDLE;
      osc_period_q <= '0;
      osc_load_q   <= 1'b0;
      osc_enable_q <= 1'b0;
      done_q       <= 1'b0;
      remain_q     <= '0;
      presc_q      <= '0;
      gap_q        <= '0;
    end else begin
      state_q      <= state_d;
      osc_period_q <= osc_period_d;
      osc_load_q   <= osc_load_d;
      osc_enable_q <= osc_enable_d;
      done_q       <= done_d;
      remain_q     <= remain_d;
      presc_q      <= presc_d;
      gap_q        <= gap_d;
    end
  end

  assign osc_period = osc_period_q;
  assign osc_load   = osc_load_q;
  assign osc_enable = osc_enable_q;
  assign done       = done_q;
  assign busy       = (state_q != IDLE);
  assign fifo_level = level_q;

endmodule

// File: tb/tb_audio_tone_sequencer.sv
// Directed bench for audio_tone_sequencer with hand-derived cycle timelines.
module tb_audio_tone_sequencer;
  localparam int FIFO_DEPTH = 4;
  localparam int PERIOD_W   = 18;
  localparam int DUR_W      = 16;
  localparam int TICK_DIV   = 4;
  localparam int GAP_CYCLES = 2;
  localparam int LVL_W      = $clog2(FIFO_DEPTH) + 1;

  logic                CLK = 1'b0;
  logic                RST;
  logic                note_valid;
  logic                note_ready;
  logic [PERIOD_W-1:0] note_period;
  logic [DUR_W-1:0]    note_dur;
  logic                start;
  logic                stop;
  logic [PERIOD_W-1:0] osc_period;
  logic                osc_load;
  logic                osc_enable;
  logic                busy;
  logic                done;
  logic [LVL_W-1:0]    fifo_level;

  int tests = 0;
  int fails = 0;

  audio_tone_sequencer #(
    .FIFO_DEPTH(FIFO_DEPTH), .PERIOD_W(PERIOD_W), .DUR_W(DUR_W),
    .TICK_DIV(TICK_DIV), .GAP_CYCLES(GAP_CYCLES)
  ) dut (
    .CLK(CLK), .RST(RST), .note_valid(note_valid), .note_ready(note_ready),
    .note_period(note_period), .note_dur(note_dur), .start(start), .stop(stop),
    .osc_period(osc_period), .osc_load(osc_load), .osc_enable(osc_enable),
    .busy(busy), .done(done), .fifo_level(fifo_level)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic push(input int p, input int d);
    note_valid  = 1'b1;
    note_period = p[PERIOD_W-1:0];
    note_dur    = d[DUR_W-1:0];
    tick();
    note_valid  = 1'b0;
  endtask

  // Collect osc_period at each osc_load until done is seen (bounded).
  task automatic collect(output int n, output int lp0, output int lp1, output int lp2,
                         output int lp3, output bit seen);
    int lp [4];
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) lp[i] = -1;
    for (int c = 0; c < 200 && !seen; c++) begin
      if (osc_load) begin
        if (n < 4) lp[n] = int'(osc_period);
        n++;
      end
      if (done) seen = 1'b1;
      else tick();
    end
    lp0 = lp[0]; lp1 = lp[1]; lp2 = lp[2]; lp3 = lp[3];
  endtask

  initial begin
    int cnt, n, a, b, c, d, ndone, nbusy;
    bit seen;
    bit e_en, e_ld;

    RST = 1'b1; note_valid = 1'b0; note_period = '0; note_dur = '0;
    start = 1'b0; stop = 1'b0;
    #1;
    chk("rst_ready", note_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_enable", osc_enable, 0);
    chk("rst_level", fifo_level, 0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // Single note (100,3)
    push(100, 3);
    chk("single_level", fifo_level, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("single_busy_load", busy, 1);
    chk("single_noload_yet", osc_load, 0);
    tick();
    chk("single_load", osc_load, 1);
    chk("single_period", osc_period, 100);
    chk("single_enable", osc_enable, 1);
    chk("single_level_pop", fifo_level, 0);
    tick();
    chk("single_load_1cyc", osc_load, 0);
    cnt = 1;
    while (osc_enable && cnt < 50) begin
      cnt++;
      tick();
    end
    chk("single_enable_len", cnt, 12);
    chk("single_gap1_busy", busy, 1);
    tick();
    chk("single_gap2_nodone", done, 0);
    tick();
    chk("single_done", done, 1);
    chk("single_idle", busy, 0);
    tick();
    chk("single_done_1cyc", done, 0);

    // Queue / back-pressure
    push(11, 1); push(22, 1); push(33, 1); push(44, 1);
    chk("queue_full_level", fifo_level, 4);
    chk("queue_full_ready", note_ready, 0);
    push(55, 1);
    chk("queue_refused_level", fifo_level, 4);
    start = 1'b1; tick(); start = 1'b0;
    collect(n, a, b, c, d, seen);
    chk("queue_done_seen", seen, 1);
    chk("queue_nloads", n, 4);
    chk("queue_p0", a, 11);
    chk("queue_p1", b, 22);
    chk("queue_p2", c, 33);
    chk("queue_p3", d, 44);
    tick();

    // Edge notes: normal, rest, zero-duration, short
    push(50, 2); push(0, 2); push(70, 0); push(80, 1);
    start = 1'b1; tick(); start = 1'b0;
    for (int k = 1; k <= 31; k++) begin
      e_en = (k >= 2 && k <= 9) || (k >= 25 && k <= 28);
      e_ld = (k == 2) || (k == 13) || (k == 25);
      chk($sformatf("edge_en_k%0d", k), osc_enable, e_en);
      chk($sformatf("edge_ld_k%0d", k), osc_load, e_ld);
      chk($sformatf("edge_done_k%0d", k), done, k == 31);
      if (k == 2)  chk("edge_p50", osc_period, 50);
      if (k == 13) chk("edge_p0", osc_period, 0);
      if (k == 25) chk("edge_p80", osc_period, 80);
      if (k == 31) chk("edge_idle", busy, 0);
      tick();
    end

    // Stop mid-run, with a write in the same cycle
    push(10, 2); push(20, 2); push(30, 2);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("stop_pre_enable", osc_enable, 1);
    chk("stop_pre_level", fifo_level, 2);
    stop = 1'b1; note_valid = 1'b1; note_period = 99; note_dur = 1;
    tick();
    stop = 1'b0; note_valid = 1'b0;
    chk("stop_busy", busy, 0);
    chk("stop_enable", osc_enable, 0);
    chk("stop_level", fifo_level, 0);
    chk("stop_ready", note_ready, 1);
    ndone = 0; nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) ndone++;
      if (busy) nbusy++;
      tick();
    end
    chk("stop_no_done", ndone, 0);
    chk("stop_stays_idle", nbusy, 0);

    // Concurrency: push while full during LOAD pop; start while busy
    push(1, 1); push(2, 1); push(3, 1); push(4, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("conc_full_ready", note_ready, 0);
    note_valid = 1'b1; note_period = 5; note_dur = 1;
    tick();
    note_valid = 1'b0;
    chk("conc_level_kept", fifo_level, 4);
    chk("conc_load", osc_load, 1);
    chk("conc_p1", osc_period, 1);
    start = 1'b1; tick(); start = 1'b0;
    chk("conc_busy_start_enable", osc_enable, 1);
    chk("conc_busy_start_noload", osc_load, 0);
    chk("conc_busy_start_level", fifo_level, 4);
    collect(n, a, b, c, d, seen);
    chk("conc_done_seen", seen, 1);
    chk("conc_nloads", n, 4);
    chk("conc_p2", a, 2);
    chk("conc_p3", b, 3);
    chk("conc_p4", c, 4);
    chk("conc_p5", d, 5);
    tick();

    // Async reset mid-PLAY
    push(9, 5);
    start = 1'b1; tick(); start = 1'b0;
    tick(); tick(); tick();
    chk("arst_pre_enable", osc_enable, 1);
    chk("arst_pre_busy", busy, 1);
    #2 RST = 1'b1;
    #1;
    chk("arst_enable", osc_enable, 0);
    chk("arst_load", osc_load, 0);
    chk("arst_busy", busy, 0);
    chk("arst_done", done, 0);
    chk("arst_level", fifo_level, 0);
    chk("arst_ready", note_ready, 1);
    chk("arst_period", osc_period, 0);
    @(negedge CLK);
    RST = 1'b0;
    tick();

    // start on empty queue is ignored
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_start_busy", busy, 0);
    tick();
    chk("empty_start_nodone", done, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
